// File: rtl/mio_pkg.sv
// mio_pkg: shared mode encodings, address map and control-word layout for the MIO counter block.
package mio_pkg;
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RATE = 2'd1;
  localparam logic [1:0] MODE_SQUARE = 2'd2;
  localparam logic [1:0] CNT_ADDR_CTRL = 2'd3;
  localparam int CTRL_SEL_LSB = 0;
  localparam int CTRL_MODE_LSB = 2;
  localparam int CTRL_EN_BIT = 4;
endpackage

// File: rtl/mio_counter_chan.sv
// mio_counter_chan: one timer channel holding count/reload/mode/enable/out.
module mio_counter_chan
  import mio_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ctrl_we,
  input  logic [1:0]       ctrl_mode,
  input  logic             ctrl_en,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       mode,
  output logic             en,
  output logic             out
);
  logic [WIDTH-1:0] reload, count_nx;
  logic act, low, rate, sq, out_nx;
  assign act = en & tick;
  assign low = count <= WIDTH'(1);
  assign rate = mode == MODE_RATE;
  assign sq = mode == MODE_SQUARE;
  // a rate pulse is cleared on the very next clk, even between prescaled ticks
  always_comb begin
    count_nx = !act ? count : (rate || sq) ? (low ? reload : count - WIDTH'(1))
             : (count != '0 ? count - WIDTH'(1) : count);
    out_nx = rate ? act & low : !act ? out : sq ? out ^ low : out | (count == WIDTH'(1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {count, reload, mode, en, out} <= '0;
    end else if (load) begin
      count <= load_val;
      reload <= load_val;
      out <= 1'b0;
    end else begin
      count <= count_nx;
      out <= (ctrl_we && ctrl_mode != mode) ? 1'b0 : out_nx;
      if (ctrl_we) begin
        mode <= ctrl_mode;
        en <= ctrl_en;
      end
    end
  end
endmodule

// File: rtl/mio_counter3.sv
// mio_counter3: three-channel programmable timer on the MIO bus.
// Define COUNTER_PRESCALE_EN to divide the count tick by PRESCALE clk cycles.
module mio_counter3
  import mio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PRESCALE = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        counter_we,
  input  logic [1:0]  counter_addr,
  input  logic [31:0] Peripheral_in,
  output logic [31:0] counter_out,
  output logic        counter0_out,
  output logic        counter1_out,
  output logic        counter2_out
);
  logic tick;
  logic [WIDTH-1:0] cnt [3];
  logic [1:0] mode [3];
  logic [2:0] en, out;
`ifdef COUNTER_PRESCALE_EN
  logic [31:0] pre;
  assign tick = pre == 32'(PRESCALE - 1);
  always_ff @(posedge clk) begin
    if (rst) pre <= '0;
    else pre <= tick ? '0 : pre + 32'd1;
  end
`else
  assign tick = 1'b1 | (PRESCALE == 0);
`endif
  for (genvar i = 0; i < 3; i++) begin : g_chan
    mio_counter_chan #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .load     (counter_we && counter_addr == 2'(i)),
      .load_val (Peripheral_in[WIDTH-1:0]),
      .ctrl_we  (counter_we && counter_addr == CNT_ADDR_CTRL
                 && Peripheral_in[CTRL_SEL_LSB +: 2] == 2'(i)),
      .ctrl_mode(Peripheral_in[CTRL_MODE_LSB +: 2]),
      .ctrl_en  (Peripheral_in[CTRL_EN_BIT]),
      .count    (cnt[i]),
      .mode     (mode[i]),
      .en       (en[i]),
      .out      (out[i])
    );
  end
  assign counter_out = counter_addr == CNT_ADDR_CTRL
    ? {16'b0, en, 1'b0, mode[2], mode[1], mode[0], 3'b0, out}
    : 32'(counter_addr[1] ? cnt[2] : counter_addr[0] ? cnt[1] : cnt[0]);
  assign {counter2_out, counter1_out, counter0_out} = out;
endmodule

// File: tb/tb_mio_counter3.sv
// tb_mio_counter3: directed self-checking bench for the three-channel timer.
module tb_mio_counter3;
  localparam int PS = 4;
  logic clk = 1'b0, rst = 1'b1, counter_we = 1'b0;
  logic [1:0] counter_addr = 2'd0;
  logic [31:0] Peripheral_in = 32'd0;
  logic [31:0] counter_out;
  logic counter0_out, counter1_out, counter2_out;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  mio_counter3 #(.WIDTH(32), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .counter_we(counter_we), .counter_addr(counter_addr),
    .Peripheral_in(Peripheral_in), .counter_out(counter_out),
    .counter0_out(counter0_out), .counter1_out(counter1_out), .counter2_out(counter2_out)
  );
  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    counter_addr = a; Peripheral_in = d; counter_we = 1'b1;
    cyc();
    counter_we = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a);
    counter_addr = a; #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; cyc(2); rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++; if ({counter2_out, counter1_out, counter0_out} !== 3'b000) begin n_bad++; $display("FAIL reset_outs: got %b want 000", {counter2_out, counter1_out, counter0_out}); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      n_cmp++; if (counter_out !== 32'h0) begin n_bad++; $display("FAIL reset_read%0d: got %h want 0", a, counter_out); end
    end
  endtask
  task automatic test_oneshot();
    do_reset(); wr(0, 32'd5); wr(3, 32'h10);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      n_cmp++; if (counter0_out !== (i == 5)) begin n_bad++; $display("FAIL oneshot_c%0d: got %b want %b", i, counter0_out, i == 5); end
    end
    cyc(3);
    n_cmp++; if (counter0_out !== 1'b1) begin n_bad++; $display("FAIL oneshot_hold: got %b want 1", counter0_out); end
    rd(0);
    n_cmp++; if (counter_out !== 32'd0) begin n_bad++; $display("FAIL oneshot_zero: got %h want 0", counter_out); end
    wr(0, 32'd3);
    n_cmp++; if (counter0_out !== 1'b0) begin n_bad++; $display("FAIL oneshot_rewrite_out: got %b want 0", counter0_out); end
    rd(0);
    n_cmp++; if (counter_out !== 32'd3) begin n_bad++; $display("FAIL oneshot_rewrite_cnt: got %h want 3", counter_out); end
  endtask
  task automatic test_rate();
    int pulses = 0;
    do_reset(); wr(1, 32'd4); wr(3, 32'h15);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      pulses += int'(counter1_out);
      n_cmp++; if (counter1_out !== (i % 4 == 0)) begin n_bad++; $display("FAIL rate_c%0d: got %b want %b", i, counter1_out, i % 4 == 0); end
    end
    n_cmp++; if (pulses !== 5) begin n_bad++; $display("FAIL rate_pulses: got %0d want 5", pulses); end
    wr(1, 32'd1);
    n_cmp++; if (counter1_out !== 1'b0) begin n_bad++; $display("FAIL rate_reload1_load: got %b want 0", counter1_out); end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_cmp++; if (counter1_out !== 1'b1) begin n_bad++; $display("FAIL rate_reload1_c%0d: got %b want 1", i, counter1_out); end
    end
  endtask
  task automatic test_square();
    do_reset(); wr(2, 32'd3); wr(3, 32'h1A);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_cmp++; if (counter2_out !== ((i / 3) % 2 == 1)) begin n_bad++; $display("FAIL square_c%0d: got %b want %b", i, counter2_out, (i / 3) % 2 == 1); end
    end
    wr(3, 32'h0A);
    n_cmp++; if (counter2_out !== 1'b1) begin n_bad++; $display("FAIL square_dis: got %b want 1", counter2_out); end
    cyc(5);
    n_cmp++; if (counter2_out !== 1'b1) begin n_bad++; $display("FAIL square_frozen_out: got %b want 1", counter2_out); end
    rd(2);
    n_cmp++; if (counter_out !== 32'd1) begin n_bad++; $display("FAIL square_frozen_cnt: got %h want 1", counter_out); end
    rd(3);
    n_cmp++; if (counter_out !== 32'h0000_0804) begin n_bad++; $display("FAIL square_frozen_stat: got %h want 00000804", counter_out); end
    wr(3, 32'h1A);
    n_cmp++; if (counter2_out !== 1'b1) begin n_bad++; $display("FAIL square_reen_out: got %b want 1", counter2_out); end
    rd(3);
    n_cmp++; if (counter_out !== 32'h0000_8804) begin n_bad++; $display("FAIL square_reen_stat: got %h want 00008804", counter_out); end
    cyc();
    rd(2);
    n_cmp++; if ({counter2_out, counter_out} !== {1'b0, 32'd3}) begin n_bad++; $display("FAIL square_resume1: got %b/%h want 0/3", counter2_out, counter_out); end
    cyc(2);
    n_cmp++; if ({counter2_out, counter_out} !== {1'b0, 32'd1}) begin n_bad++; $display("FAIL square_resume3: got %b/%h want 0/1", counter2_out, counter_out); end
    cyc();
    n_cmp++; if ({counter2_out, counter_out} !== {1'b1, 32'd3}) begin n_bad++; $display("FAIL square_resume4: got %b/%h want 1/3", counter2_out, counter_out); end
    rst = 1'b1; cyc(); rst = 1'b0;
    n_cmp++; if (counter2_out !== 1'b0) begin n_bad++; $display("FAIL midreset_out: got %b want 0", counter2_out); end
    rd(2);
    n_cmp++; if (counter_out !== 32'd0) begin n_bad++; $display("FAIL midreset_cnt: got %h want 0", counter_out); end
    rd(3);
    n_cmp++; if (counter_out !== 32'd0) begin n_bad++; $display("FAIL midreset_stat: got %h want 0", counter_out); end
  endtask
  task automatic test_collision();
    do_reset(); wr(1, 32'd4); wr(3, 32'h15);
    cyc(3); rd(1);
    n_cmp++; if (counter_out !== 32'd1) begin n_bad++; $display("FAIL coll_pre: got %h want 1", counter_out); end
    wr(1, 32'd9); rd(1);
    n_cmp++; if ({counter1_out, counter_out} !== {1'b0, 32'd9}) begin n_bad++; $display("FAIL coll_write: got %b/%h want 0/9", counter1_out, counter_out); end
    cyc(); rd(1);
    n_cmp++; if ({counter1_out, counter_out} !== {1'b0, 32'd8}) begin n_bad++; $display("FAIL coll_next: got %b/%h want 0/8", counter1_out, counter_out); end
  endtask
  task automatic test_ignore();
    do_reset(); wr(3, 32'h09); rd(3);
    n_cmp++; if (counter_out !== 32'h0000_0200) begin n_bad++; $display("FAIL ign_base: got %h want 00000200", counter_out); end
    wr(3, 32'h1F); rd(3);
    n_cmp++; if (counter_out !== 32'h0000_0200) begin n_bad++; $display("FAIL ign_1f: got %h want 00000200", counter_out); end
    wr(3, 32'h13); rd(3);
    n_cmp++; if (counter_out !== 32'h0000_0200) begin n_bad++; $display("FAIL ign_13: got %h want 00000200", counter_out); end
  endtask
  task automatic test_prescale();
    do_reset(); wr(0, 32'd2); wr(3, 32'h10);
`ifdef COUNTER_PRESCALE_EN
    begin
      int n = 0;
      while (!counter0_out && n < 4 * PS) begin cyc(); n++; end
      n_cmp++; if (n <= PS || n > 2 * PS) begin n_bad++; $display("FAIL prescale_rise: got %0d cycles want %0d..%0d", n, PS + 1, 2 * PS); end
    end
`else
    cyc();
    n_cmp++; if (counter0_out !== 1'b0) begin n_bad++; $display("FAIL prescale_c1: got %b want 0", counter0_out); end
    cyc();
    n_cmp++; if (counter0_out !== 1'b1) begin n_bad++; $display("FAIL prescale_c2: got %b want 1", counter0_out); end
`endif
  endtask
  initial begin
    test_reset();
    test_oneshot();
    test_rate();
    test_square();
    test_collision();
    test_ignore();
    test_prescale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
